// File: rtl/alu_serial_wide_if.sv
// alu_serial_wide_if: operand and result handshakes for alu_serial_wide.
// Signals:
//   in_valid, in_ready, a, b, op      operand channel (source -> ALU)
//   out_valid, out_ready, res, cout, zero  result channel (ALU -> consumer)
// Modports:
//   master  source/consumer side
//   slave   ALU side
interface alu_serial_wide_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         cout;
    logic         zero;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, res, cout, zero
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, res, cout, zero
    );
endinterface

// File: rtl/alu_serial_wide.sv
// alu_serial_wide: W-bit ALU (ADD/SUB/AND/OR), one nibble per clock, LSB first.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  alu_serial_wide_if.slave: operand in, registered result out
module alu_serial_wide #(
    parameter int NIBBLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    alu_serial_wide_if.slave   bus
);
    localparam int W = 4 * NIBBLES;
    localparam logic [2:0] LAST = 3'(NIBBLES - 1);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t       state;
    logic [2:0]   idx;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [1:0]   op_q;
    logic         carry;
    logic [W-1:0] res_q;
    logic         cout_q;
    logic         zero_q;
    logic         in_ready_q;
    logic         out_valid_q;

    logic [4:0]   shamt;
    logic [3:0]   a_nib;
    logic [3:0]   b_nib;
    logic [4:0]   sum;
    logic [3:0]   nib;
    logic         carry_next;
    logic [W-1:0] res_next;

    // Current nibble slice and its result merged into the result word.
    // SUB is a + ~b + 1, the +1 coming from carry preset at accept.
    always_comb begin
        shamt      = {idx, 2'b00};
        a_nib      = 4'(a_q >> shamt);
        b_nib      = 4'(b_q >> shamt);
        sum        = {1'b0, a_nib}
                   + {1'b0, b_nib ^ {4{op_q == OP_SUB}}}
                   + {4'b0000, carry};
        nib        = sum[3:0];
        carry_next = sum[4];
        unique case (op_q)
            OP_ADD, OP_SUB: ;
            OP_AND: begin
                nib        = a_nib & b_nib;
                carry_next = 1'b0;
            end
            OP_OR: begin
                nib        = a_nib | b_nib;
                carry_next = 1'b0;
            end
        endcase
        res_next = (res_q & ~(W'(4'hF) << shamt))
                 | (W'(nib) << shamt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_ADD;
            carry       <= 1'b0;
            res_q       <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        op_q       <= bus.op;
                        idx        <= '0;
                        carry      <= (bus.op == OP_SUB);
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    res_q <= res_next;
                    carry <= carry_next;
                    if (idx == LAST) begin
                        cout_q      <= carry_next;
                        zero_q      <= (res_next == '0);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                DONE: begin
                    // in_valid is ignored here even when out_ready is
                    // high, so a new op always waits one IDLE cycle.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.res       = res_q;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_serial_wide.sv
// tb_alu_serial_wide: directed and random checks of alu_serial_wide
// (NIBBLES=4) against a plain-arithmetic reference model.
module tb_alu_serial_wide;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    alu_serial_wide_if #(.NIBBLES(4)) bus ();

    alu_serial_wide #(.NIBBLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] model(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic [1:0] o);
        logic [16:0] r;
        case (o)
            2'd0:    r = {1'b0, x} + {1'b0, y};
            2'd1:    r = {(x >= y), 16'(x - y)};
            2'd2:    r = {1'b0, x & y};
            default: r = {1'b0, x | y};
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [15:0] x,
                          input logic [15:0] y, input logic [1:0] o,
                          input logic [15:0] eres, input logic ecout,
                          input int hold);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, " in_ready"}, 32'(bus.in_ready), 1);
        bus.a = x;
        bus.b = y;
        bus.op = o;
        bus.in_valid = 1'b1;
        tick();
        // scramble sources: the ALU must use its latched copies
        bus.in_valid = 1'b0;
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        bus.op = 2'($urandom);
        check({tag, " busy"}, 32'(bus.in_ready), 0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, 4);
        check({tag, " res"}, 32'(bus.res), 32'(eres));
        check({tag, " cout"}, 32'(bus.cout), 32'(ecout));
        check({tag, " zero"}, 32'(bus.zero), 32'(eres == 16'h0));
        if (hold > 0) begin
            repeat (hold) tick();
            check({tag, " held"}, 32'(bus.res), 32'(eres));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, " consumed"}, 32'(bus.out_valid), 0);
        check({tag, " idle"}, 32'(bus.in_ready), 1);
    endtask

    initial begin
        logic [16:0] e;
        logic [15:0] x;
        logic [15:0] y;
        logic [1:0]  o;
        int          seen;

        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.op = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst in_ready", 32'(bus.in_ready), 1);
        check("rst out_valid", 32'(bus.out_valid), 0);
        check("rst res", 32'(bus.res), 0);
        check("rst cout", 32'(bus.cout), 0);
        check("rst zero", 32'(bus.zero), 0);

        run_op("add carry", 16'h00FF, 16'h0001, 2'd0, 16'h0100, 1'b0, 0);
        run_op("add wrap", 16'hFFFF, 16'h0001, 2'd0, 16'h0000, 1'b1, 0);
        run_op("sub borrow", 16'h0003, 16'h0004, 2'd1, 16'hFFFF, 1'b0, 1);
        run_op("sub equal", 16'h1234, 16'h1234, 2'd1, 16'h0000, 1'b1, 0);
        run_op("and", 16'hB0C3, 16'h0FF0, 2'd2, 16'h00C0, 1'b0, 0);
        run_op("or", 16'hB0C3, 16'h0FF0, 2'd3, 16'hBFF3, 1'b0, 2);

        // backpressure in DONE
        bus.a = 16'h1111;
        bus.b = 16'h2222;
        bus.op = 2'd0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        check("bp valid", 32'(bus.out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            tick();
            check("bp res", 32'(bus.res), 32'h3333);
            check("bp flags", {30'd0, bus.cout, bus.zero}, 0);
            check("bp in_ready", 32'(bus.in_ready), 0);
            check("bp out_valid", 32'(bus.out_valid), 1);
        end
        bus.a = 16'h0005;
        bus.b = 16'h0003;
        bus.op = 2'd1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp consume", 32'(bus.out_valid), 0);
        check("bp not taken", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        check("bp taken", 32'(bus.in_ready), 0);
        repeat (4) tick();
        check("bp2 valid", 32'(bus.out_valid), 1);
        check("bp2 res", 32'(bus.res), 32'h0002);
        check("bp2 cout", 32'(bus.cout), 1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // reset in the middle of RUN, when idx has reached 2
        bus.a = 16'hFFFF;
        bus.b = 16'hFFFF;
        bus.op = 2'd0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst in_ready", 32'(bus.in_ready), 1);
        check("mid rst out_valid", 32'(bus.out_valid), 0);
        check("mid rst res", 32'(bus.res), 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("mid rst stale", seen, 0);
        run_op("post rst add", 16'h0001, 16'h0001, 2'd0, 16'h0002, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            if (i % 8 == 0) y = x;
            o = 2'($urandom);
            e = model(x, y, o);
            run_op("rnd", x, y, o, e[15:0], e[16], int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
